// File: rtl/lsu_pkg.sv
// Shared types and constants for the wb_lsu load/store unit.
package lsu_pkg;

  localparam int LANES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] is the access size, funct3[2] the unsigned flag; 011/11x have no meaning.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension, and access legality check.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       a,
  input  logic             we,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  raw,
  output logic [LANES-1:0] sel,
  output logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  rdata,
  output logic             bad
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = raw[{a, 3'b000} +: 8];
  assign ld_half = a[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    sel     = '0;
    wb_data = '0;
    rdata   = '0;
    case (funct3[1:0])
      2'b00: begin
        sel     = 4'b0001 << a;
        wb_data = {4{wdata[7:0]}};
        rdata   = funct3[2] ? {{(XLEN-8){1'b0}}, ld_byte}
                            : {{(XLEN-8){ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        sel     = a[1] ? 4'b1100 : 4'b0011;
        wb_data = {2{wdata[15:0]}};
        rdata   = funct3[2] ? {{(XLEN-16){1'b0}}, ld_half}
                            : {{(XLEN-16){ld_half[15]}}, ld_half};
      end
      2'b10: begin
        sel     = 4'b1111;
        wb_data = wdata;
        rdata   = raw;
      end
      default: ;
    endcase
    // Loads drive no write data onto the bus.
    if (!we) wb_data = '0;
  end

  assign bad = f3_illegal(funct3)
             || ((funct3[1:0] == 2'b01) && a[0])
             || ((funct3[1:0] == 2'b10) && (a != 2'b00));

endmodule

// File: rtl/wb_lsu.sv
// Load/store unit: one CPU request -> one pipelined Wishbone transaction.
// Define LSU_TIMEOUT_EN to abandon bus cycles that see no ack/err within TIMEOUT cycles.
module wb_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_addr,
  input  logic [XLEN-1:0]  i_wdata,
  output logic             o_busy,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_rdata,
  output logic             o_misalign,
  output logic             o_err,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [XLEN-1:0]  o_wb_addr,
  output logic [XLEN-1:0]  o_wb_data,
  output logic [LANES-1:0] o_wb_sel,
  input  logic             i_wb_stall,
  input  logic             i_wb_ack,
  input  logic             i_wb_err,
  input  logic [XLEN-1:0]  i_wb_data
);

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       a_q, a_d;
  logic             busy_q, busy_d, valid_q, valid_d, mis_q, mis_d, err_q, err_d;
  logic             cyc_q, cyc_d, stb_q, stb_d, wbwe_q, wbwe_d;
  logic [XLEN-1:0]  rdata_q, rdata_d, wbaddr_q, wbaddr_d, wbdata_q, wbdata_d;
  logic [LANES-1:0] sel_q, sel_d;

  // In IDLE the aligner looks at the incoming request; afterwards at the latched one.
  logic             idle;
  logic [2:0]       al_f3;
  logic [1:0]       al_a;
  logic             al_we, al_bad;
  logic [LANES-1:0] al_sel;
  logic [XLEN-1:0]  al_wbdata, al_rdata;

  assign idle  = (state_q == S_IDLE);
  assign al_f3 = idle ? i_funct3 : f3_q;
  assign al_a  = idle ? i_addr[1:0] : a_q;
  assign al_we = idle ? i_we : we_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3  (al_f3),
    .a       (al_a),
    .we      (al_we),
    .wdata   (i_wdata),
    .raw     (i_wb_data),
    .sel     (al_sel),
    .wb_data (al_wbdata),
    .rdata   (al_rdata),
    .bad     (al_bad)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    a_d     = a_q;
    rdata_d = '0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (i_req) begin
        we_d    = i_we;
        f3_d    = i_funct3;
        a_d     = i_addr[1:0];
        state_d = al_bad ? S_FAULT : S_REQ;
      end
      S_REQ:  if (!i_wb_stall) state_d = S_WAIT;
      S_WAIT: if (i_wb_err) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end else if (i_wb_ack) begin
        state_d = S_DONE;
        rdata_d = we_q ? '0 : al_rdata;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef LSU_TIMEOUT_EN
    cnt_d = cnt_q;
    if (state_d == S_REQ && state_q != S_REQ) cnt_d = '0;
    else if (state_q == S_REQ || state_q == S_WAIT) cnt_d = cnt_q + 1'b1;
    // A genuine ack/err in the same cycle wins over the watchdog.
    if ((state_q == S_REQ || state_q == S_WAIT) && state_d != S_DONE
        && cnt_q == CNT_W'(TIMEOUT)) begin
      state_d = S_DONE;
      err_d   = 1'b1;
    end
`endif

    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE) || (state_d == S_FAULT);
    mis_d   = (state_d == S_FAULT);
    cyc_d   = (state_d == S_REQ) || (state_d == S_WAIT);
    stb_d   = (state_d == S_REQ);

    if (idle && state_d == S_REQ) begin
      wbwe_d   = i_we;
      wbaddr_d = {2'b00, i_addr[XLEN-1:2]};
      wbdata_d = al_wbdata;
      sel_d    = al_sel;
    end else if (cyc_d) begin
      wbwe_d   = wbwe_q;
      wbaddr_d = wbaddr_q;
      wbdata_d = wbdata_q;
      sel_d    = sel_q;
    end else begin
      wbwe_d   = 1'b0;
      wbaddr_d = '0;
      wbdata_d = '0;
      sel_d    = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      f3_q     <= '0;
      a_q      <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      wbwe_q   <= 1'b0;
      wbaddr_q <= '0;
      wbdata_q <= '0;
      sel_q    <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      wbwe_q   <= wbwe_d;
      wbaddr_q <= wbaddr_d;
      wbdata_q <= wbdata_d;
      sel_q    <= sel_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign o_busy     = busy_q;
  assign o_valid    = valid_q;
  assign o_rdata    = rdata_q;
  assign o_misalign = mis_q;
  assign o_err      = err_q;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = stb_q;
  assign o_wb_we    = wbwe_q;
  assign o_wb_addr  = wbaddr_q;
  assign o_wb_data  = wbdata_q;
  assign o_wb_sel   = sel_q;

endmodule

// File: tb/tb_wb_lsu.sv
// Directed self-checking bench for wb_lsu with a behavioural pipelined Wishbone slave.
module tb_wb_lsu;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_req, i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata;
  logic        o_busy, o_valid, o_misalign, o_err;
  logic [31:0] o_rdata;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0] i_wb_data;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  wb_lsu dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req(i_req), .i_we(i_we),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_valid(o_valid), .o_rdata(o_rdata),
    .o_misalign(o_misalign), .o_err(o_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Issues one request at cycle 0 and plays the slave; resp: 0=ack, 1=err, 2=silent.
  // lat is the cycle o_valid was seen (-1 if never within the budget).
  task automatic run_access(
    input  logic        we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
    input  int          stall, input logic [31:0] rd, input int resp, input bit poke,
    output int          lat, output logic [31:0] rdata, output logic verr, output logic vmis,
    output logic        saw_cyc, output logic stable, output logic cyc_at_valid,
    output logic [31:0] a_seen, output logic [31:0] d_seen, output logic [3:0] s_seen);
    int  n_stall;
    bit  first;
    n_stall = stall; first = 1'b1;
    lat = -1; rdata = 'x; verr = 1'bx; vmis = 1'bx; saw_cyc = 1'b0; stable = 1'b1;
    cyc_at_valid = 1'bx; a_seen = 'x; d_seen = 'x; s_seen = 'x;
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    for (int c = 1; c <= 40; c++) begin
      step();
      i_req = poke && (c == 2 || c == 3);
      if (i_req) begin i_addr = 32'h0000_0200; i_we = 1'b0; i_funct3 = F3W(); end
      i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
      if (o_wb_cyc) saw_cyc = 1'b1;
      if (o_valid) begin
        lat = c; rdata = o_rdata; verr = o_err; vmis = o_misalign; cyc_at_valid = o_wb_cyc;
        break;
      end
      if (o_wb_stb) begin
        if (first) begin
          a_seen = o_wb_addr; d_seen = o_wb_data; s_seen = o_wb_sel; first = 1'b0;
        end else if (o_wb_addr !== a_seen || o_wb_data !== d_seen || o_wb_sel !== s_seen
                     || o_wb_we !== we) begin
          stable = 1'b0;
        end
        i_wb_stall = (n_stall > 0);
        if (n_stall > 0) n_stall--;
      end else if (o_wb_cyc) begin
        if (resp == 0) begin i_wb_ack = 1'b1; i_wb_data = rd; end
        else if (resp == 1) begin i_wb_err = 1'b1; i_wb_data = rd; end
      end
    end
    i_req = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
  endtask

  function automatic logic [2:0] F3W();
    return 3'b010;
  endfunction

  int lat; logic [31:0] rd, a_s, d_s; logic ve, vm, sc, st, cv; logic [3:0] s_s;

  task automatic test_reset();
    i_reset_n = 1'b0; i_req = 0; i_we = 0; i_funct3 = 0; i_addr = 0; i_wdata = 0;
    i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0; i_wb_data = 0;
    #23;
    checks++;
    if ({o_busy, o_valid, o_misalign, o_err, o_wb_cyc, o_wb_stb, o_wb_we} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {o_busy, o_valid, o_misalign, o_err, o_wb_cyc, o_wb_stb, o_wb_we});
    end
    checks++;
    if ({o_rdata, o_wb_addr, o_wb_data, o_wb_sel} !== 100'b0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %b expected all 0",
        o_rdata, o_wb_addr, o_wb_data, o_wb_sel);
    end
    step(); i_reset_n = 1'b1; step();
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b expected 0", o_busy); end
  endtask

  task automatic test_store_byte();
    run_access(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 0, 32'h0, 0, 1'b0,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d expected 3", lat); end
    checks++; if (a_s !== 32'h40) begin errors++; $display("FAIL sb_addr: got %h expected 00000040", a_s); end
    checks++; if (s_s !== 4'b1000) begin errors++; $display("FAIL sb_sel: got %b expected 1000", s_s); end
    checks++; if (d_s !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_data: got %h expected a5a5a5a5", d_s); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sb_rdata: got %h expected 0", rd); end
    checks++; if ({ve, vm} !== 2'b00) begin errors++; $display("FAIL sb_flags: got %b expected 00", {ve, vm}); end
    step();
  endtask

  task automatic test_load_byte();
    run_access(1'b0, 3'b000, 32'h102, 32'h0, 0, 32'h1280_3456, 0, 1'b0,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", rd); end
    checks++; if (s_s !== 4'b0100) begin errors++; $display("FAIL lb_sel: got %b expected 0100", s_s); end
    step();
    run_access(1'b0, 3'b100, 32'h102, 32'h0, 0, 32'h1280_3456, 0, 1'b0,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata: got %h expected 00000080", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL lbu_latency: got %0d expected 3", lat); end
    step();
  endtask

  task automatic test_load_half();
    run_access(1'b0, 3'b001, 32'h106, 32'h0, 0, 32'hBEEF_1234, 0, 1'b0,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if (rd !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_rdata: got %h expected ffffbeef", rd); end
    checks++; if (s_s !== 4'b1100) begin errors++; $display("FAIL lh_sel: got %b expected 1100", s_s); end
    checks++; if (a_s !== 32'h41) begin errors++; $display("FAIL lh_addr: got %h expected 00000041", a_s); end
    step();
    run_access(1'b0, 3'b101, 32'h100, 32'h0, 0, 32'h1234_8001, 0, 1'b0,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu_rdata: got %h expected 00008001", rd); end
    step();
  endtask

  task automatic test_misalign();
    run_access(1'b0, 3'b010, 32'h105, 32'h0, 0, 32'h0, 0, 1'b0,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if (lat !== 1) begin errors++; $display("FAIL mis_w_latency: got %0d expected 1", lat); end
    checks++; if ({vm, ve} !== 2'b10) begin errors++; $display("FAIL mis_w_flags: got %b expected 10", {vm, ve}); end
    checks++; if (sc !== 1'b0) begin errors++; $display("FAIL mis_w_cyc: got %b expected 0", sc); end
    step();
    run_access(1'b1, 3'b001, 32'h101, 32'h1234, 0, 32'h0, 0, 1'b0,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if ({lat == 1, vm, sc} !== 3'b110) begin errors++; $display("FAIL mis_h: got lat=%0d mis=%b cyc=%b expected 1 1 0", lat, vm, sc); end
    step();
    run_access(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 0, 1'b0,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if ({lat == 1, vm, sc} !== 3'b110) begin errors++; $display("FAIL illegal_f3: got lat=%0d mis=%b cyc=%b expected 1 1 0", lat, vm, sc); end
    step();
  endtask

  task automatic test_stall();
    run_access(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 3, 32'h0, 0, 1'b1,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if (lat !== 6) begin errors++; $display("FAIL stall_latency: got %0d expected 6", lat); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL stall_stable: got %b expected 1", st); end
    checks++; if ({a_s, d_s, s_s} !== {32'h2, 32'hDEAD_BEEF, 4'b1111}) begin
      errors++; $display("FAIL stall_bus: got %h %h %b expected 00000002 deadbeef 1111", a_s, d_s, s_s);
    end
    step(); step();
    checks++; if ({o_busy, o_wb_cyc} !== 2'b00) begin errors++; $display("FAIL ignored_req: got busy,cyc=%b expected 00", {o_busy, o_wb_cyc}); end
  endtask

  task automatic test_bus_err();
    run_access(1'b0, 3'b010, 32'h10, 32'h0, 0, 32'hFFFF_FFFF, 1, 1'b0,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if ({lat == 3, ve, vm} !== 3'b110) begin errors++; $display("FAIL berr_flags: got lat=%0d err=%b mis=%b expected 3 1 0", lat, ve, vm); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL berr_rdata: got %h expected 0", rd); end
    step();
  endtask

  task automatic test_reset_abort();
    bit saw_valid;
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h20;
    step(); i_req = 1'b0;
    step();
    checks++; if ({o_wb_cyc, o_wb_stb} !== 2'b10) begin errors++; $display("FAIL abort_wait: got cyc,stb=%b expected 10", {o_wb_cyc, o_wb_stb}); end
    i_reset_n = 1'b0; #1;
    checks++; if ({o_wb_cyc, o_wb_stb, o_busy} !== 3'b000) begin errors++; $display("FAIL abort_now: got %b expected 000", {o_wb_cyc, o_wb_stb, o_busy}); end
    i_wb_ack = 1'b1; i_wb_data = 32'h5555_5555;
    step(); i_wb_ack = 1'b0; i_reset_n = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin step(); if (o_valid || o_busy) saw_valid = 1'b1; end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet: got %b expected 0", saw_valid); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 3'b001, 32'h202, 32'h0000_CAFE, 0, 32'h0, 0, 1'b0,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if ({s_s, d_s} !== {4'b1100, 32'hCAFE_CAFE}) begin errors++; $display("FAIL b2b_sh: got %b %h expected 1100 cafecafe", s_s, d_s); end
    step();
    run_access(1'b0, 3'b000, 32'h201, 32'h0, 0, 32'h0000_7F00, 0, 1'b0,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if ({lat == 3, rd} !== {1'b1, 32'h0000_007F}) begin errors++; $display("FAIL b2b_lb: got lat=%0d rdata=%h expected 3 0000007f", lat, rd); end
    step();
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    run_access(1'b0, 3'b010, 32'h30, 32'h0, 0, 32'h0, 2, 1'b0,
               lat, rd, ve, vm, sc, st, cv, a_s, d_s, s_s);
    checks++; if (lat !== 17) begin errors++; $display("FAIL timeout_latency: got %0d expected 17", lat); end
    checks++; if ({ve, cv, rd} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL timeout_flags: got err=%b cyc=%b rdata=%h expected 1 0 0", ve, cv, rd); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_store_byte();
    test_load_byte();
    test_load_half();
    test_misalign();
    test_stall();
    test_bus_err();
    test_reset_abort();
    test_back_to_back();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
